// File: rtl/linear_network_pkg.sv
// Shared types for the linear-network injectors: FIFO entry layout and feeder FSM states.
package linear_network_pkg;

  localparam int unsigned LN_DATA_WIDTH = 32;
  localparam int unsigned LN_NUM_NODE   = 4;
  localparam int unsigned LN_CMD_WIDTH  = $clog2(LN_NUM_NODE);

  typedef struct packed {
    logic [LN_DATA_WIDTH-1:0] data;
    logic [LN_CMD_WIDTH-1:0]  dest;
  } ln_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BLOCKED = 2'd2
  } ln_state_t;

endpackage

// File: rtl/linear_network_unicast_feeder_if.sv
// Upstream stream, issue control and network-facing outputs of the unicast feeder.
interface linear_network_unicast_feeder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned COMMAND_WIDTH = $clog2(NUM_NODE);
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1;

  logic                     i_valid;
  logic [DATA_WIDTH-1:0]    i_data_bus;
  logic [COMMAND_WIDTH-1:0] i_dest;
  logic                     i_auto;
  logic                     o_ready;
  logic                     i_en;
  logic [NUM_NODE-1:0]      i_node_ready;
  logic                     o_valid;
  logic [DATA_WIDTH-1:0]    o_data_bus;
  logic                     o_en;
  logic [COMMAND_WIDTH-1:0] o_cmd;
  logic [CNT_W-1:0]         o_count;
  logic                     o_blocked;

  modport master (
    output i_valid, i_data_bus, i_dest, i_auto, i_en, i_node_ready,
    input  o_ready, o_valid, o_data_bus, o_en, o_cmd, o_count, o_blocked
  );

  modport slave (
    input  i_valid, i_data_bus, i_dest, i_auto, i_en, i_node_ready,
    output o_ready, o_valid, o_data_bus, o_en, o_cmd, o_count, o_blocked
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a combinational head read; no bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/linear_network_unicast_feeder.sv
// Buffered unicast injector: queues {data, dest} words and issues the head when its node is ready.
module linear_network_unicast_feeder
  import linear_network_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LN_DATA_WIDTH,
  parameter int unsigned NUM_NODE   = LN_NUM_NODE,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_LEN  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  linear_network_unicast_feeder_if.slave bus
);
  localparam int unsigned COMMAND_WIDTH = $clog2(NUM_NODE);
  localparam int unsigned ENTRY_W       = DATA_WIDTH + COMMAND_WIDTH;
  localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BURST_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned PAD_W         = 1 << COMMAND_WIDTH;

  logic                     push;
  logic                     go;
  logic                     full;
  logic                     empty;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic [ENTRY_W-1:0]       wr_entry;
  logic [ENTRY_W-1:0]       head;
  logic [COMMAND_WIDTH-1:0] head_dest;
  logic [DATA_WIDTH-1:0]    head_data;
  logic [COMMAND_WIDTH-1:0] dest_sel;
  logic [PAD_W-1:0]         ready_pad;
  logic [COMMAND_WIDTH-1:0] rr_dest;
  logic [BURST_W-1:0]       burst_cnt;
  ln_state_t                state;
  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     en_q;
  logic [COMMAND_WIDTH-1:0] cmd_q;

  assign push      = bus.i_valid && !full;
  assign dest_sel  = bus.i_auto ? rr_dest : bus.i_dest;
  assign wr_entry  = {bus.i_data_bus, dest_sel};
  assign head_dest = head[COMMAND_WIDTH-1:0];
  assign head_data = head[ENTRY_W-1:COMMAND_WIDTH];
  // Padding keeps the ready lookup in range for non-power-of-two node counts.
  assign ready_pad = PAD_W'(bus.i_node_ready);
  assign go        = bus.i_en && !empty && ready_pad[head_dest];
  assign cnt_next  = cnt + CNT_W'(push) - CNT_W'(go);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (go),
    .wdata (wr_entry),
    .rdata (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  // Round-robin destination: advances after BURST_LEN auto-mode pushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_dest   <= '0;
      burst_cnt <= '0;
    end else if (push && bus.i_auto) begin
      if (burst_cnt == BURST_W'(BURST_LEN - 1)) begin
        burst_cnt <= '0;
        rr_dest   <= (rr_dest == COMMAND_WIDTH'(NUM_NODE - 1)) ? '0
                                                               : rr_dest + COMMAND_WIDTH'(1);
      end else begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

  // Issue FSM and network-facing output registers; a just-filled FIFO counts as about to issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      cmd_q   <= '0;
    end else begin
      valid_q <= go;
      en_q    <= bus.i_en;
      if (go) begin
        data_q <= head_data;
        cmd_q  <= head_dest;
      end
      if (cnt_next == '0)    state <= ST_IDLE;
      else if (go || empty)  state <= ST_ISSUE;
      else                   state <= ST_BLOCKED;
    end
  end

  assign bus.o_ready    = !full;
  assign bus.o_valid    = valid_q;
  assign bus.o_data_bus = data_q;
  assign bus.o_en       = en_q;
  assign bus.o_cmd      = cmd_q;
  assign bus.o_count    = cnt;
  assign bus.o_blocked  = (state == ST_BLOCKED);

endmodule

// File: tb/tb_linear_network_unicast_feeder.sv
// Scoreboard bench: queue-based reference model predicts issues; a negedge monitor compares.
module tb_linear_network_unicast_feeder;
  import linear_network_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned NN    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BL    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linear_network_unicast_feeder_if #(.DATA_WIDTH(DW), .NUM_NODE(NN), .FIFO_DEPTH(DEPTH)) bus ();

  linear_network_unicast_feeder #(
    .DATA_WIDTH (DW),
    .NUM_NODE   (NN),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  ln_entry_t fq[$];
  ln_entry_t sb_q[$];
  int        auto_cnt = 0;
  logic      exp_valid = 1'b0;
  logic      exp_en = 1'b0;
  int        exp_count = 0;
  bit        mon_on = 1'b0;
  int        cyc = 0;
  int        obs_cmd[$];
  int        obs_cyc[$];
  int        exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one FIFO of pending words plus a queue of words already issued.
  always @(posedge clk) begin : model
    bit        g;
    bit        acc;
    ln_entry_t e;
    cyc++;
    if (!rst_n) begin
      fq.delete();
      sb_q.delete();
      auto_cnt  = 0;
      exp_valid = 1'b0;
      exp_en    = 1'b0;
    end else begin
      acc = bus.i_valid && (fq.size() < DEPTH);
      g   = bus.i_en && (fq.size() != 0) && bus.i_node_ready[fq[0].dest];
      if (g) sb_q.push_back(fq.pop_front());
      if (acc) begin
        e.data = bus.i_data_bus;
        if (bus.i_auto) begin
          e.dest = 2'((auto_cnt / BL) % NN);
          auto_cnt++;
        end else begin
          e.dest = bus.i_dest;
        end
        fq.push_back(e);
      end
      exp_valid = g;
      exp_en    = bus.i_en;
    end
    exp_count = fq.size();
    mon_on    = 1'b1;
  end

  always @(negedge clk) begin : monitor
    ln_entry_t e;
    if (mon_on) begin
      chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
      chk("o_count", 32'(bus.o_count), 32'(exp_count));
      chk("o_ready", 32'(bus.o_ready), 32'(exp_count < DEPTH));
      chk("o_en", 32'(bus.o_en), 32'(exp_en));
      if (exp_count == 0) chk("o_blocked_idle", 32'(bus.o_blocked), 32'd0);
      if (bus.o_valid === 1'b1) begin
        obs_cmd.push_back(int'(bus.o_cmd));
        obs_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue act=cmd%0d/%0h exp=none", bus.o_cmd, bus.o_data_bus);
        end else begin
          e = sb_q.pop_front();
          chk("o_data_bus", bus.o_data_bus, e.data);
          chk("o_cmd", 32'(bus.o_cmd), 32'(e.dest));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] dst, input logic a);
    bus.i_valid    = v;
    bus.i_data_bus = d;
    bus.i_dest     = dst;
    bus.i_auto     = a;
  endtask

  task automatic clear_obs();
    obs_cmd.delete();
    obs_cyc.delete();
  endtask

  initial begin
    bus.i_valid      = 1'b1;
    bus.i_data_bus   = 32'h1234_5678;
    bus.i_dest       = 2'd0;
    bus.i_auto       = 1'b0;
    bus.i_en         = 1'b0;
    bus.i_node_ready = 4'hF;

    // Reset held for two edges while upstream is valid
    step(2);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", bus.o_data_bus, 32'd0);
    chk("rst_cmd", 32'(bus.o_cmd), 32'd0);
    chk("rst_en", 32'(bus.o_en), 32'd0);
    chk("rst_blocked", 32'(bus.o_blocked), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_count", 32'(bus.o_count), 32'd0);

    // Explicit unicast: two-cycle latency
    bus.i_en = 1'b1;
    drive(1'b1, 32'hAAAA_AAAA, 2'd2, 1'b0);
    step();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    chk("uni_lat1_valid", 32'(bus.o_valid), 32'd0);
    step();
    chk("uni_valid", 32'(bus.o_valid), 32'd1);
    chk("uni_cmd", 32'(bus.o_cmd), 32'd2);
    chk("uni_data", bus.o_data_bus, 32'hAAAA_AAAA);
    step(3);

    // Auto round-robin, BURST_LEN=2
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 2'd3, 1'b1);
      step();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    step(4);
    chk("auto_n", 32'(obs_cmd.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_cmd.size(); i++) begin
      chk("auto_cmd", 32'(obs_cmd[i]), 32'(exp_seq[i]));
      chk("auto_b2b", 32'(obs_cyc[i] - obs_cyc[0]), 32'(i));
    end
    drive(1'b1, 32'h99, 2'd3, 1'b1);
    step();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    step(3);
    chk("auto_wrap_n", 32'(obs_cmd.size()), 32'd9);
    if (obs_cmd.size() > 8) chk("auto_wrap_cmd", 32'(obs_cmd[8]), 32'd0);

    // Head-of-line blocking on node 1
    clear_obs();
    bus.i_node_ready = 4'b1101;
    drive(1'b1, 32'h11, 2'd1, 1'b0);
    step();
    drive(1'b1, 32'h22, 2'd0, 1'b0);
    step();
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    step(3);
    chk("blk_blocked", 32'(bus.o_blocked), 32'd1);
    chk("blk_valid", 32'(bus.o_valid), 32'd0);
    chk("blk_count", 32'(bus.o_count), 32'd2);
    bus.i_node_ready = 4'hF;
    step();
    chk("blk_rel_valid", 32'(bus.o_valid), 32'd1);
    chk("blk_rel_data", bus.o_data_bus, 32'h11);
    step();
    chk("blk_rel2_data", bus.o_data_bus, 32'h22);
    chk("blk_rel2_cmd", 32'(bus.o_cmd), 32'd0);
    step(2);

    // Full then drain
    clear_obs();
    bus.i_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 2'(i % 4), 1'b0);
      step();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    chk("full_count", 32'(bus.o_count), 32'd8);
    bus.i_en = 1'b1;
    step(12);
    chk("drain_count", 32'(bus.o_count), 32'd0);
    chk("drain_blocked", 32'(bus.o_blocked), 32'd0);
    chk("drain_n", 32'(obs_cmd.size()), 32'd8);

    // Simultaneous push/pop at count 3, then reset with 5 entries
    bus.i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 2'(i), 1'b0);
      step();
    end
    chk("sim_pre_count", 32'(bus.o_count), 32'd3);
    bus.i_en = 1'b1;
    drive(1'b1, 32'h203, 2'd3, 1'b0);
    step();
    chk("sim_count", 32'(bus.o_count), 32'd3);
    bus.i_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h210 + 32'(i), 2'(i), 1'b0);
      step();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    chk("mid_count", 32'(bus.o_count), 32'd5);
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 32'(bus.o_count), 32'd0);
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;
    bus.i_en = 1'b1;
    clear_obs();
    step(10);
    chk("mid_rst_none", 32'(obs_cmd.size()), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'(($urandom % 4) != 0), $urandom, 2'($urandom % NN), 1'($urandom % 2));
      bus.i_en         = 1'(($urandom % 8) != 0);
      bus.i_node_ready = 4'($urandom);
      step();
    end
    drive(1'b0, 32'd0, 2'd0, 1'b0);
    bus.i_en         = 1'b1;
    bus.i_node_ready = 4'hF;
    for (int i = 0; i < 40 && (fq.size() != 0 || sb_q.size() != 0); i++) step();
    step(2);
    chk("rand_fifo_drained", 32'(fq.size()), 32'd0);
    chk("rand_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
